rv_muldiv_unit: RTL

//  RV32M/RV64M multiply-divide execution unit for the RISC-V core datapath. It sits beside the
//  ALU, receives rs1/rs2 data plus funct3, and returns the rd write-back value.

---
 rtl/rv_muldiv_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rv_muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: shift-add (or single-step) multiply, restoring divide,
// start/done handshake with busy stall and synchronous kill.
module rv_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    // state | meaning
    // IDLE  | waiting for start; done pulses here for one cycle after FIN
    // CALC  | one multiply/divide iteration per edge, count_q counts down to 1
    // FIN   | sign correction and result select, result/done registered
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, result_q;
    logic [2*XLEN-1:0] p_q;
    logic [CW-1:0]     count_q;
    logic              neg_q, neg_a_q, div0_q, ovf_q, done_q;

    logic              is_div_d, sgn_a_d, sgn_b_d, neg_a_d, neg_b_d, div0_d, ovf_d, to_fin_d;
    logic [XLEN-1:0]   a_mag_d, b_mag_d;

    always_comb begin
        is_div_d = op[2];
        sgn_a_d  = is_div_d ? ~op[0] : (op != 3'd3);
        sgn_b_d  = is_div_d ? ~op[0] : ~op[1];
        neg_a_d  = sgn_a_d & rs1[XLEN-1];
        neg_b_d  = sgn_b_d & rs2[XLEN-1];
        a_mag_d  = neg_a_d ? -rs1 : rs1;
        b_mag_d  = neg_b_d ? -rs2 : rs2;
        div0_d   = is_div_d & (rs2 == '0);
        ovf_d    = is_div_d & ~op[0] & (rs1 == MIN_NEG) & (&rs2);
        to_fin_d = is_div_d ? (div0_d | ovf_d) : MUL_FAST;
    end

    // p_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide
    logic [XLEN:0]     mul_sum_d, div_shift_d;
    logic              div_ge_d;
    logic [XLEN-1:0]   div_rem_d;
    logic [2*XLEN-1:0] p_d;

    always_comb begin
        mul_sum_d   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
        div_shift_d = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        div_ge_d    = div_shift_d >= {1'b0, b_q};
        div_rem_d   = XLEN'(div_ge_d ? div_shift_d - {1'b0, b_q} : div_shift_d);
        if (op_q[2])
            p_d = {div_rem_d, p_q[XLEN-2:0], div_ge_d};
        else
            p_d = {mul_sum_d, p_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod_d, prod_s_d;
    logic [XLEN-1:0]   quo_d, rem_d, fin_d;

    always_comb begin
        prod_d   = MUL_FAST ? ({{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q}) : p_q;
        prod_s_d = neg_q ? -prod_d : prod_d;
        quo_d    = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
        rem_d    = neg_a_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
        if (!op_q[2])
            fin_d = (op_q == 3'd0) ? prod_s_d[XLEN-1:0] : prod_s_d[2*XLEN-1:XLEN];
        else if (div0_q)
            fin_d = op_q[1] ? (neg_a_q ? -a_q : a_q) : '1;
        else if (ovf_q)
            fin_d = op_q[1] ? '0 : a_q;
        else
            fin_d = op_q[1] ? rem_d : quo_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (kill) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a_mag_d;
                        b_q     <= b_mag_d;
                        neg_q   <= neg_a_d ^ neg_b_d;
                        neg_a_q <= neg_a_d;
                        div0_q  <= div0_d;
                        ovf_q   <= ovf_d;
                        p_q     <= {{XLEN{1'b0}}, is_div_d ? a_mag_d : b_mag_d};
                        count_q <= CW'(XLEN);
                        state_q <= to_fin_d ? FIN : CALC;
                    end
                end
                CALC: begin
                    p_q     <= p_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1))
                        state_q <= FIN;
                end
                FIN: begin
                    result_q <= fin_d;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
